// File: rtl/serial_pkg.sv
// Framing definitions shared by the serial transmitter and the matching
// receiver FSM, so both ends agree on line levels and frame states.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Bit-period prescaler: counts 0..DIV-1 and flags the last cycle of each
// period. A synchronous clear holds it at zero (used while the line is idle).
module tick_gen #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    // Next count: wrap on the last cycle of the period, hold at zero on clear.
    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Prescaler register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Framed serial transmitter: latches a switch pattern on start and shifts it
// out as start bit, data LSB-first, stop bit, each bit lasting DIV clocks.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 25_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             presc_clear;

    // Holding the prescaler cleared throughout IDLE means it is already zero
    // on the cycle a start is accepted, so every non-IDLE state spans DIV clocks.
    assign presc_clear = (state_q == IDLE);

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .clear(presc_clear),
        .tick (tick)
    );

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

    // Next-state, shift/count update and registered output values.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d  = data;
                    bitcnt_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it.
        unique case (state_d)
            IDLE:    out_d = LINE_IDLE;
            START:   out_d = START_LEVEL;
            DATA:    out_d = shreg_d[0];
            STOP:    out_d = STOP_LEVEL;
            default: out_d = LINE_IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            out_q    <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a WIDTH=8/DIV=4 instance and a WIDTH=1/DIV=2
// instance, each with a per-cycle expectation queue filled when frames start.
module tb_serial_pattern_tx;

    typedef struct packed {
        logic o;
        logic b;
        logic d;
    } exp_t;

    localparam exp_t IDLE_EXP = '{o: 1'b1, b: 1'b0, d: 1'b0};

    logic       clock = 1'b0;
    logic       reset0 = 1'b1;
    logic       start0 = 1'b0;
    logic [7:0] data0  = 8'h00;
    logic       out0, busy0, done0;

    logic       reset1 = 1'b1;
    logic       start1 = 1'b0;
    logic [0:0] data1  = 1'b0;
    logic       out1, busy1, done1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clock = ~clock;

    serial_pattern_tx #(.WIDTH(8), .DIV(4)) dut0 (
        .clock(clock), .reset(reset0), .start(start0), .data(data0),
        .out(out0), .busy(busy0), .done(done0)
    );

    serial_pattern_tx #(.WIDTH(1), .DIV(2)) dut1 (
        .clock(clock), .reset(reset1), .start(start1), .data(data1),
        .out(out1), .busy(busy1), .done(done1)
    );

    function automatic void push_frame0(input logic [7:0] d);
        for (int i = 0; i < 4; i++) q0.push_back('{o: 1'b0, b: 1'b1, d: 1'b0});
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 4; i++) q0.push_back('{o: d[b], b: 1'b1, d: 1'b0});
        for (int i = 0; i < 4; i++) q0.push_back('{o: 1'b1, b: 1'b1, d: 1'b0});
        q0.push_back('{o: 1'b1, b: 1'b0, d: 1'b1});
    endfunction

    function automatic void push_frame1(input logic d);
        for (int i = 0; i < 2; i++) q1.push_back('{o: 1'b0, b: 1'b1, d: 1'b0});
        for (int i = 0; i < 2; i++) q1.push_back('{o: d, b: 1'b1, d: 1'b0});
        for (int i = 0; i < 2; i++) q1.push_back('{o: 1'b1, b: 1'b1, d: 1'b0});
        q1.push_back('{o: 1'b1, b: 1'b0, d: 1'b1});
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge and compare both DUTs against
    // the front of their queues (idle line when nothing is queued).
    task automatic step();
        exp_t e0, e1;
        @(posedge clock);
        #1;
        cyc++;
        e0 = (q0.size() != 0) ? q0.pop_front() : IDLE_EXP;
        e1 = (q1.size() != 0) ? q1.pop_front() : IDLE_EXP;
        chk("w8_out",  out0,  e0.o);
        chk("w8_busy", busy0, e0.b);
        chk("w8_done", done0, e0.d);
        chk("w1_out",  out1,  e1.o);
        chk("w1_busy", busy1, e1.b);
        chk("w1_done", done1, e1.d);
    endtask

    task automatic drain();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 200) begin
            step();
            guard++;
        end
    endtask

    initial begin
        // 1. reset for 3 cycles, then idle for 20
        for (int i = 0; i < 3; i++) step();
        reset0 = 1'b0;
        reset1 = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // 2. single frame A5, start pulsed for one edge
        data0 = 8'hA5;
        start0 = 1'b1;
        push_frame0(8'hA5);
        step();
        start0 = 1'b0;
        data0 = 8'h00;
        drain();
        for (int i = 0; i < 3; i++) step();

        // 3. start with FF, second start with 00 while busy must be ignored
        data0 = 8'hFF;
        start0 = 1'b1;
        push_frame0(8'hFF);
        step();
        start0 = 1'b0;
        for (int i = 0; i < 9; i++) step();
        data0 = 8'h00;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        drain();
        for (int i = 0; i < 5; i++) step();

        // 4. start held high: second frame starts right after the done cycle
        data0 = 8'h01;
        start0 = 1'b1;
        push_frame0(8'h01);
        push_frame0(8'h01);
        for (int i = 0; i < 50; i++) step();
        start0 = 1'b0;
        drain();
        for (int i = 0; i < 3; i++) step();

        // 5. reset asserted mid-frame aborts it with no done pulse
        data0 = 8'h3C;
        start0 = 1'b1;
        push_frame0(8'h3C);
        step();
        start0 = 1'b0;
        for (int i = 0; i < 14; i++) step();
        reset0 = 1'b1;
        q0.delete();
        step();
        reset0 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        start0 = 1'b1;
        push_frame0(8'h3C);
        step();
        start0 = 1'b0;
        drain();

        // reset and start together: reset wins, nothing captured
        reset0 = 1'b1;
        start0 = 1'b1;
        data0 = 8'h55;
        step();
        reset0 = 1'b0;
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // 6. WIDTH=1, DIV=2 frames with data 0 then 1
        data1 = 1'b0;
        start1 = 1'b1;
        push_frame1(1'b0);
        step();
        start1 = 1'b0;
        drain();
        step();
        data1 = 1'b1;
        start1 = 1'b1;
        push_frame1(1'b1);
        step();
        start1 = 1'b0;
        drain();
        for (int i = 0; i < 3; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
